led_pattern_monitor: RTL and testbench
======================================

# led_pattern_monitor

Receive-side checker for the RGB LED bus that drives the board LEDs. It samples the red, green and blue LED vectors and detects every pattern change. Each change is classified as shift-left, shift-right, flash or other, and the interval between changes is measured. It locks once the pattern is stable and flags stalls and pattern breaks. It sits on the LED outputs in benches and in on-board self-test, as the observer end of the LED interface.

## Interface
- N_LEDS, 4, LEDs per colour channel; legal range ≥3, because rotate-left and rotate-right must differ.
- NB_PERIOD, 16, width of the interval counter and of o_period.
- N_LOCK, 3, consecutive matching events needed to lock; legal range 2..15.
- clock  in  1  system clock; single clock domain.
- ck_rst  in  1  synchronous, active-low reset.
- i_led_r  in  N_LEDS  red LED vector.
- i_led_g  in  N_LEDS  green LED vector.
- i_led_b  in  N_LEDS  blue LED vector.
- o_class  out  2  class of the last event: 0 OTHER, 1 SHIFT_L, 2 SHIFT_R, 3 FLASH.
- o_period  out  NB_PERIOD  clocks between the last two events.
- o_color  out  3  {red active, green active, blue active} at the last non-blank event.
- o_change  out  1  one-cycle pulse per event.
- o_locked  out  1  high while in LOCK.
- o_error  out  1  one-cycle pulse on a lock break or stall.

## Operation
- Sample register: led_q <= {r,g,b} every cycle. Reset value 0.
- Event (ev): the current {r,g,b} differs from led_q.
- Combined patterns:
  - c_prev = bitwise OR of the three channels of led_q.
  - c_cur = bitwise OR of the three live inputs.
- Classification, evaluated on ev:
  - SHIFT_L: c_prev is one-hot and c_cur = c_prev rotated left by 1 (MSB wraps to bit 0).
  - SHIFT_R: c_prev is one-hot and c_cur = c_prev rotated right by 1.
  - FLASH: c_prev = 0 and c_cur = all ones, or c_prev = all ones and c_cur = 0.
  - OTHER: any other transition.
- Interval counter cnt:
  - Reset value 0.
  - On ev, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at 2^NB_PERIOD−1.
  - At an event, cnt equals the number of clocks since the previous event. A saturated value is invalid and never matches.
- On every ev:
  - o_class <= class.
  - o_period <= cnt.
  - o_change pulses.
  - o_color <= {|r,|g,|b}, only when c_cur ≠ 0; otherwise o_color holds.
- Match rule: an event matches when all of the following hold:
  - its class equals the previous event's class;
  - its class is not OTHER;
  - cnt equals the previous event's o_period;
  - cnt is not saturated.
- Match counter mcnt (4 bits):
  - On a matching event, mcnt <= mcnt+1.
  - On a non-OTHER event that does not match, mcnt <= 1.
  - On an OTHER event, mcnt <= 0.
- FSM, states IDLE / ACQ / LOCK; reset state IDLE:
  - IDLE: a non-OTHER ev → ACQ.
  - ACQ:
    - When a matching ev brings mcnt to N_LOCK → LOCK, and latch lock_period <= cnt.
    - An OTHER ev → IDLE.
  - LOCK:
    - A matching ev with cnt = lock_period → stay.
    - Any other non-OTHER ev → ACQ with mcnt=1, and o_error pulses.
    - An OTHER ev → IDLE, and o_error pulses.
    - Stall: no ev and cnt = lock_period → IDLE, and o_error pulses. This fires on the first clock on which the expected change is late.
- o_locked = (state == LOCK), registered.
- Ev and stall cannot coincide, because stall requires no ev. A mismatch in class and period at the same event gives a single o_error pulse.
- Reset asserted mid-operation returns every register to its reset value on the next edge, regardless of state.

## Timing
- All outputs are registered.
- Reset values:
  - o_class=0, o_period=0, o_color=0.
  - o_change=0, o_locked=0, o_error=0.
  - Internals: led_q=0, cnt=0, mcnt=0, lock_period=0, state IDLE.
- An input change at edge k (the first cycle it is stable) causes ev during cycle k. o_change, o_class, o_period and o_color update at edge k+1.
- The FSM transition, o_locked and o_error also appear at edge k+1.
- A stall detected in cycle k gives o_error high for cycle k+1 only.
- The monitor is combinational-free on its outputs. Inputs are assumed synchronous to clock; asynchronous inputs are synchronised upstream.

## Test plan
- Red-only shift-left, advancing every 4 clocks (0001→0010→0100→1000→0001…):
  - o_class=1, o_period=4 and o_color=3'b100 after each event.
  - o_locked rises at edge+1 of the 4th event and stays high.
- All-colour flash, toggling 0000↔1111 every 6 clocks: o_class=3, o_period=6, o_color=3'b111, lock after the 4th event.
- Lock at shift period 4, then hold the pattern: exactly one o_error pulse 5 clocks after the last change; o_locked drops the same cycle.
- Lock on shift-left, then inject a shift-right step at period 4: one o_error pulse, o_locked=0, o_class=2. Relock requires N_LOCK−1 further matching events.
- Lock, then pull ck_rst low for 1 cycle mid-pattern: all outputs return to 0 next edge. Relock requires the full event sequence again.
- NB_PERIOD=4 with changes 20 clocks apart: o_period=15 (saturated) and o_locked never asserts.

Source files
------------

// File: rtl/led_pattern_monitor.sv
// led_pattern_monitor
// Observer for the RGB LED bus. Samples the three colour vectors every clock,
// detects each pattern change, classifies it (shift-left, shift-right, flash,
// other), measures the clock interval between changes and locks onto a steady
// repeating pattern. Stalls and pattern breaks while locked raise o_error.
//
// Output contract: o_change and o_error are single-cycle qualifiers. o_class,
// o_period, o_color and o_locked are only meaningful on a cycle where o_change
// or o_error is high, and they hold their values in between. There is no
// back-pressure: the observer never stalls the LED bus and a consumer must
// sample on every qualifier pulse.

module led_pattern_monitor #(
  parameter int N_LEDS    = 4,
  parameter int NB_PERIOD = 16,
  parameter int N_LOCK    = 3
) (
  input  logic                 clock,
  input  logic                 ck_rst,
  input  logic [N_LEDS-1:0]    i_led_r,
  input  logic [N_LEDS-1:0]    i_led_g,
  input  logic [N_LEDS-1:0]    i_led_b,
  output logic [1:0]           o_class,
  output logic [NB_PERIOD-1:0] o_period,
  output logic [2:0]           o_color,
  output logic                 o_change,
  output logic                 o_locked,
  output logic                 o_error,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam logic [1:0] CL_OTHER = 2'd0;
  localparam logic [1:0] CL_SHL   = 2'd1;
  localparam logic [1:0] CL_SHR   = 2'd2;
  localparam logic [1:0] CL_FLASH = 2'd3;

  localparam logic [NB_PERIOD-1:0] CNT_MAX  = '1;
  localparam logic [NB_PERIOD-1:0] CNT_ONE  = NB_PERIOD'(1);
  localparam logic [N_LEDS-1:0]    ALL_ON   = '1;
  localparam logic [N_LEDS-1:0]    ALL_OFF  = '0;
  localparam logic [3:0]           LOCK_CNT = 4'(N_LOCK);

  state_t                   state;
  state_t                   state_next;
  logic [3*N_LEDS-1:0]      led_q;
  logic [3*N_LEDS-1:0]      led_cur;
  logic [N_LEDS-1:0]        c_prev;
  logic [N_LEDS-1:0]        c_cur;
  logic [N_LEDS-1:0]        rot_l;
  logic [N_LEDS-1:0]        rot_r;
  logic                     ev;
  logic [1:0]               ev_class;
  logic [NB_PERIOD-1:0]     cnt;
  logic                     cnt_sat;
  logic                     match;
  logic [3:0]               mcnt;
  logic [3:0]               mcnt_inc;
  logic [3:0]               mcnt_next;
  logic [NB_PERIOD-1:0]     lock_period;
  logic                     lock_load;
  logic                     error_next;

  // Live and previous patterns; colours are merged so classification ignores hue.
  assign led_cur  = {i_led_r, i_led_g, i_led_b};
  assign c_prev   = led_q[3*N_LEDS-1:2*N_LEDS] | led_q[2*N_LEDS-1:N_LEDS] | led_q[N_LEDS-1:0];
  assign c_cur    = i_led_r | i_led_g | i_led_b;
  assign ev       = (led_cur != led_q);
  assign rot_l    = {c_prev[N_LEDS-2:0], c_prev[N_LEDS-1]};
  assign rot_r    = {c_prev[0], c_prev[N_LEDS-1:1]};
  assign cnt_sat  = (cnt == CNT_MAX);
  assign mcnt_inc = mcnt + 4'd1;

  // A saturated interval is unknown, so it can never confirm a repeat.
  assign match = ev && (ev_class == o_class) && (ev_class != CL_OTHER) &&
                 (cnt == o_period) && !cnt_sat;

  // Classify the transition from the previous combined pattern to the live one.
  always_comb begin
    ev_class = CL_OTHER;
    if ($onehot(c_prev) && (c_cur == rot_l)) begin
      ev_class = CL_SHL;
    end else if ($onehot(c_prev) && (c_cur == rot_r)) begin
      ev_class = CL_SHR;
    end else if (((c_prev == ALL_OFF) && (c_cur == ALL_ON)) ||
                 ((c_prev == ALL_ON) && (c_cur == ALL_OFF))) begin
      ev_class = CL_FLASH;
    end
  end

  // Sample register and saturating interval counter restarted by each change.
  always_ff @(posedge clock) begin
    if (!ck_rst) begin
      led_q <= '0;
      cnt   <= '0;
    end else begin
      led_q <= led_cur;
      if (ev) begin
        cnt <= CNT_ONE;
      end else if (!cnt_sat) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // Next-state, match-run and error decisions for the lock tracker.
  always_comb begin
    state_next = state;
    error_next = 1'b0;
    lock_load  = 1'b0;
    mcnt_next  = mcnt;
    if (ev) begin
      if (match) begin
        mcnt_next = mcnt_inc;
      end else if (ev_class != CL_OTHER) begin
        mcnt_next = 4'd1;
      end else begin
        mcnt_next = 4'd0;
      end
    end
    case (state)
      ST_IDLE: begin
        if (ev && (ev_class != CL_OTHER)) begin
          state_next = ST_ACQ;
        end
      end
      ST_ACQ: begin
        if (ev) begin
          if (match && (mcnt_inc == LOCK_CNT)) begin
            state_next = ST_LOCK;
            lock_load  = 1'b1;
          end else if (ev_class == CL_OTHER) begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_LOCK: begin
        if (ev) begin
          if (match && (cnt == lock_period)) begin
            state_next = ST_LOCK;
          end else if (ev_class != CL_OTHER) begin
            state_next = ST_ACQ;
            mcnt_next  = 4'd1;
            error_next = 1'b1;
          end else begin
            state_next = ST_IDLE;
            error_next = 1'b1;
          end
        end else if (cnt == lock_period) begin
          // The expected change is late by one clock: drop the lock now.
          state_next = ST_IDLE;
          error_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Tracker state register, match-run counter and latched lock interval.
  always_ff @(posedge clock) begin
    if (!ck_rst) begin
      state       <= ST_IDLE;
      mcnt        <= 4'd0;
      lock_period <= '0;
    end else begin
      state <= state_next;
      mcnt  <= mcnt_next;
      if (lock_load) begin
        lock_period <= cnt;
      end
    end
  end

  // Registered event report and status outputs.
  always_ff @(posedge clock) begin
    if (!ck_rst) begin
      o_class  <= CL_OTHER;
      o_period <= '0;
      o_color  <= 3'b000;
      o_change <= 1'b0;
      o_locked <= 1'b0;
      o_error  <= 1'b0;
    end else begin
      o_change <= ev;
      o_error  <= error_next;
      o_locked <= (state_next == ST_LOCK);
      if (ev) begin
        o_class  <= ev_class;
        o_period <= cnt;
        if (c_cur != ALL_OFF) begin
          o_color <= {|i_led_r, |i_led_g, |i_led_b};
        end
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Bench for led_pattern_monitor: directed scenarios plus random segments,
// compared against a reference model of the change/lock rules through an
// expected-record queue. A second instance with a 4-bit interval counter
// covers saturation.

module tb_led_pattern_monitor;

  localparam int N    = 4;
  localparam int NL   = 3;
  localparam int MAXP = 65535;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         ck_rst;
  logic [N-1:0] i_led_r, i_led_g, i_led_b;
  logic [1:0]   o_class;
  logic [15:0]  o_period;
  logic [2:0]   o_color;
  logic         o_change, o_locked, o_error;
  logic [1:0]   o_state;

  logic [N-1:0] sat_r, sat_g, sat_b;
  logic [1:0]   sat_class;
  logic [3:0]   sat_period;
  logic [2:0]   sat_color;
  logic         sat_change, sat_locked, sat_error;
  logic [1:0]   sat_state;
  bit           sat_seen_lock;

  led_pattern_monitor #(.N_LEDS(N), .NB_PERIOD(16), .N_LOCK(NL)) u_dut (
    .clock(clock), .ck_rst(ck_rst),
    .i_led_r(i_led_r), .i_led_g(i_led_g), .i_led_b(i_led_b),
    .o_class(o_class), .o_period(o_period), .o_color(o_color),
    .o_change(o_change), .o_locked(o_locked), .o_error(o_error),
    .o_state(o_state)
  );

  led_pattern_monitor #(.N_LEDS(N), .NB_PERIOD(4), .N_LOCK(NL)) u_sat (
    .clock(clock), .ck_rst(ck_rst),
    .i_led_r(sat_r), .i_led_g(sat_g), .i_led_b(sat_b),
    .o_class(sat_class), .o_period(sat_period), .o_color(sat_color),
    .o_change(sat_change), .o_locked(sat_locked), .o_error(sat_error),
    .o_state(sat_state)
  );

  // ---------------- scoreboard state ----------------
  // record = {change, error, locked, class[1:0], color[2:0], period[15:0]}
  logic [23:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [11:0] m_led;
  int          m_since, m_class, m_period, m_run, lock_p;
  logic [2:0]  m_color;
  bit          m_locked, m_track;

  function automatic logic [3:0] rotl(input logic [3:0] p);
    int pv;
    pv = int'(p);
    return 4'((pv * 2) % 16 + pv / 8);
  endfunction

  function automatic logic [3:0] rotr(input logic [3:0] p);
    int pv;
    pv = int'(p);
    return 4'(pv / 2 + (pv % 2) * 8);
  endfunction

  function automatic int classify(input logic [3:0] p, input logic [3:0] c);
    if ($countones(p) == 1 && c == rotl(p)) return 1;
    if ($countones(p) == 1 && c == rotr(p)) return 2;
    if ((p == 4'h0 && c == 4'hF) || (p == 4'hF && c == 4'h0)) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_led = '0; m_since = 0; m_class = 0; m_period = 0; m_run = 0;
    lock_p = 0; m_color = 3'b000; m_locked = 0; m_track = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    logic [11:0] cur;
    int cls, new_run;
    bit match, err;
    cur = {r, g, b};
    if (cur != m_led) begin
      cls   = classify(m_led[11:8] | m_led[7:4] | m_led[3:0], r | g | b);
      match = (cls == m_class) && (cls != 0) && (m_since == m_period) && (m_since != MAXP);
      new_run = match ? (m_run + 1) % 16 : ((cls != 0) ? 1 : 0);
      err = 0;
      if (m_locked) begin
        if (!(match && m_since == lock_p)) begin
          err = 1;
          m_locked = 0;
          m_track = (cls != 0);
          if (cls != 0) new_run = 1;
        end
      end else if (m_track) begin
        if (match && new_run == NL) begin
          m_locked = 1;
          lock_p = m_since;
        end else if (cls == 0) begin
          m_track = 0;
        end
      end else if (cls != 0) begin
        m_track = 1;
      end
      m_run = new_run;
      m_class = cls;
      m_period = m_since;
      if ((r | g | b) != 4'h0) m_color = {|r, |g, |b};
      m_since = 1;
      exp_q.push_back({1'b1, err, m_locked, 2'(m_class), m_color, 16'(m_period)});
    end else begin
      if (m_locked && m_since == lock_p) begin
        m_locked = 0;
        m_track = 0;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 2'(m_class), m_color, 16'(m_period)});
      end
      if (m_since < MAXP) m_since++;
    end
    m_led = cur;
  endtask

  // ---------------- driver tasks ----------------
  logic [3:0] last_r = '0, last_g = '0, last_b = '0;

  task automatic tick(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                      input logic rst_n);
    i_led_r = r; i_led_g = g; i_led_b = b; ck_rst = rst_n;
    last_r = r; last_g = g; last_b = b;
    if (!rst_n) model_reset();
    else model_step(r, g, b);
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                      input int n);
    for (int i = 0; i < n; i++) tick(r, g, b, 1'b1);
  endtask

  task automatic drive(input logic [2:0] cm, input logic [3:0] p, input int n);
    hold(cm[2] ? p : 4'h0, cm[1] ? p : 4'h0, cm[0] ? p : 4'h0, n);
  endtask

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [23:0] got, exp;
    if (sat_locked) sat_seen_lock = 1;
    if (o_change || o_error) begin
      got = {o_change, o_error, o_locked, o_class, o_color, o_period};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_report t=%0t got chg=%0b err=%0b lck=%0b cls=%0d col=%b per=%0d required none",
                 $time, o_change, o_error, o_locked, o_class, o_color, o_period);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL report t=%0t got chg=%0b err=%0b lck=%0b cls=%0d col=%b per=%0d required chg=%0b err=%0b lck=%0b cls=%0d col=%b per=%0d",
                   $time, got[23], got[22], got[21], got[20:19], got[18:16], got[15:0],
                   exp[23], exp[22], exp[21], exp[20:19], exp[18:16], exp[15:0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] p;
    logic [3:0] sp;
    sat_seen_lock = 0;
    sat_r = '0; sat_g = '0; sat_b = '0;
    i_led_r = '0; i_led_g = '0; i_led_b = '0;
    ck_rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_class", o_class, 0);
    check("reset_period", o_period, 0);
    check("reset_color", o_color, 0);
    check("reset_change", o_change, 0);
    check("reset_locked", o_locked, 0);
    check("reset_error", o_error, 0);
    @(posedge clock);
    #1;

    // Red shift-left every 4 clocks, then hold to provoke a stall.
    p = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      hold(p, 4'h0, 4'h0, 4);
      if (i < 9) p = rotl(p);
    end
    hold(p, 4'h0, 4'h0, 8);

    // Green shift-left lock, then switch direction to shift-right.
    for (int i = 0; i < 6; i++) begin
      p = rotl(p);
      hold(4'h0, p, 4'h0, 4);
    end
    for (int i = 0; i < 5; i++) begin
      p = rotr(p);
      hold(4'h0, p, 4'h0, 4);
    end

    // Blue shift-left lock, one-cycle reset mid-pattern, then relock.
    for (int i = 0; i < 6; i++) begin
      p = rotl(p);
      hold(4'h0, 4'h0, p, 4);
    end
    tick(4'h0, 4'h0, p, 1'b0);
    @(negedge clock);
    check("midrst_class", o_class, 0);
    check("midrst_period", o_period, 0);
    check("midrst_color", o_color, 0);
    check("midrst_change", o_change, 0);
    check("midrst_locked", o_locked, 0);
    check("midrst_error", o_error, 0);
    @(posedge clock);
    #1;
    for (int i = 0; i < 7; i++) begin
      p = rotl(p);
      hold(4'h0, 4'h0, p, 4);
    end

    // All-colour flash every 6 clocks.
    p = 4'h0;
    for (int i = 0; i < 8; i++) begin
      p = ~p;
      hold(p, p, p, 6);
    end

    // Random segments: shifts, flashes and junk with random colours and jitter.
    for (int s = 0; s < 30; s++) begin
      int mode, per, nev, hp;
      logic [2:0] cm;
      mode = $urandom_range(0, 3);
      per  = $urandom_range(2, 7);
      nev  = $urandom_range(3, 7);
      cm   = 3'($urandom_range(1, 7));
      for (int e = 0; e < nev; e++) begin
        hp = per;
        if ($urandom_range(0, 9) == 0) hp = per + 1;
        case (mode)
          0: p = ($countones(p) == 1) ? rotl(p) : 4'(1 << $urandom_range(0, 3));
          1: p = ($countones(p) == 1) ? rotr(p) : 4'(1 << $urandom_range(0, 3));
          2: p = (p == 4'h0) ? 4'hF : 4'h0;
          default: p = 4'($urandom_range(0, 15));
        endcase
        drive(cm, p, hp);
      end
      if ($urandom_range(0, 3) == 0) hold(last_r, last_g, last_b, per + 3);
    end

    // Saturation instance: changes 20 clocks apart never give a valid period.
    sp = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      sat_r = sp;
      hold(last_r, last_g, last_b, 20);
      sp = rotl(sp);
    end
    check("sat_period", sat_period, 15);
    check("sat_class", sat_class, 1);
    check("sat_never_locked", sat_seen_lock, 0);

    hold(last_r, last_g, last_b, 10);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
